// File: rtl/popcount_pkg.sv
// Shared definitions for the popcount stream accumulator: FSM state encoding and the
// width of an 8-bit popcount result.
package popcount_pkg;

    localparam logic ST_ACCUM = 1'b0;
    localparam logic ST_HOLD  = 1'b1;

    localparam int unsigned POP_W = 4;

endpackage

// File: rtl/popcount_int8.sv
// Combinational popcount of one 8-bit word, result in 0..8.
module popcount_int8
    import popcount_pkg::*;
(
    input  logic [7:0]       data,
    output logic [POP_W-1:0] pop
);

    always_comb begin
        pop = '0;
        for (int i = 0; i < 8; i++) begin
            pop = pop + POP_W'(data[i]);
        end
    end

endmodule

// File: rtl/popcount_stream_accum.sv
// Accumulates per-word popcounts over an in_last-delimited frame and presents the frame
// total and beat count. Define POPCOUNT_ACCUM_SAT_EN to saturate the accumulator instead of wrapping.
module popcount_stream_accum
    import popcount_pkg::*;
#(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned ACC_WIDTH  = 16,
    parameter int unsigned BEAT_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      in_data,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ACC_WIDTH-1:0]  out_count,
    output logic [BEAT_WIDTH-1:0] out_beats,
    output logic                  out_overflow
);

    logic                  state_q, state_d;
    logic [ACC_WIDTH-1:0]  acc_q, acc_d;
    logic [BEAT_WIDTH-1:0] beats_q, beats_d;
    logic                  ovf_q, ovf_d;
    logic [ACC_WIDTH-1:0]  out_count_q, out_count_d;
    logic [BEAT_WIDTH-1:0] out_beats_q, out_beats_d;
    logic                  out_ovf_q, out_ovf_d;

    logic [POP_W-1:0]      pop;
    logic [ACC_WIDTH:0]    sum;
    logic                  carry;
    logic [ACC_WIDTH-1:0]  acc_next;
    logic [BEAT_WIDTH-1:0] beats_next;
    logic                  ovf_next;

    popcount_int8 u_popcount (
        .data (in_data),
        .pop  (pop)
    );

    always_comb begin
        sum   = {1'b0, acc_q} + (ACC_WIDTH + 1)'(pop);
        carry = sum[ACC_WIDTH];
`ifdef POPCOUNT_ACCUM_SAT_EN
        acc_next = carry ? '1 : sum[ACC_WIDTH-1:0];
`else
        acc_next = sum[ACC_WIDTH-1:0];
`endif
        beats_next = (&beats_q) ? beats_q : beats_q + 1'b1;
        ovf_next   = ovf_q | carry;
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        beats_d     = beats_q;
        ovf_d       = ovf_q;
        out_count_d = out_count_q;
        out_beats_d = out_beats_q;
        out_ovf_d   = out_ovf_q;
        if (state_q == ST_ACCUM) begin
            if (in_valid) begin
                acc_d   = acc_next;
                beats_d = beats_next;
                ovf_d   = ovf_next;
                if (in_last) begin
                    out_count_d = acc_next;
                    out_beats_d = beats_next;
                    out_ovf_d   = ovf_next;
                    state_d     = ST_HOLD;
                end
            end
        end else begin
            // Result consumed: start the next frame from a clean accumulator.
            if (out_ready) begin
                acc_d   = '0;
                beats_d = '0;
                ovf_d   = 1'b0;
                state_d = ST_ACCUM;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_ACCUM;
            acc_q       <= '0;
            beats_q     <= '0;
            ovf_q       <= 1'b0;
            out_count_q <= '0;
            out_beats_q <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            beats_q     <= beats_d;
            ovf_q       <= ovf_d;
            out_count_q <= out_count_d;
            out_beats_q <= out_beats_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign in_ready     = (state_q == ST_ACCUM);
    assign out_valid    = (state_q == ST_HOLD);
    assign out_count    = out_count_q;
    assign out_beats    = out_beats_q;
    assign out_overflow = out_ovf_q;

endmodule

// File: tb/tb_popcount_stream_accum.sv
// Scoreboard bench for popcount_stream_accum: a wide instance (ACC_WIDTH=16) and a narrow
// one (ACC_WIDTH=4) for overflow; expectations follow POPCOUNT_ACCUM_SAT_EN.
module tb_popcount_stream_accum;

    typedef struct {
        logic [15:0] cnt;
        logic [11:0] beats;
        logic        ovf;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, in_last, out_valid, out_ready, out_overflow;
    logic [7:0]  in_data;
    logic [15:0] out_count;
    logic [11:0] out_beats;

    logic        n_in_valid, n_in_ready, n_in_last, n_out_valid, n_out_ready, n_out_overflow;
    logic [7:0]  n_in_data;
    logic [3:0]  n_out_count;
    logic [11:0] n_out_beats;

    exp_t q[$];
    exp_t nq[$];
    int   total = 0;
    int   bad   = 0;
    logic rand_done;

    always #5 clk = ~clk;

    popcount_stream_accum dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_last      (in_last),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_count    (out_count),
        .out_beats    (out_beats),
        .out_overflow (out_overflow)
    );

    popcount_stream_accum #(
        .ACC_WIDTH (4)
    ) dut_narrow (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (n_in_valid),
        .in_ready     (n_in_ready),
        .in_data      (n_in_data),
        .in_last      (n_in_last),
        .out_valid    (n_out_valid),
        .out_ready    (n_out_ready),
        .out_count    (n_out_count),
        .out_beats    (n_out_beats),
        .out_overflow (n_out_overflow)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitors: a result transfers at the edge following a negedge with valid && ready.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (q.size() == 0) begin
                check("unexpected_result", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("out_count", 32'(out_count), 32'(e.cnt));
                check("out_beats", 32'(out_beats), 32'(e.beats));
                check("out_overflow", 32'(out_overflow), 32'(e.ovf));
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && n_out_valid && n_out_ready) begin
            if (nq.size() == 0) begin
                check("narrow_unexpected_result", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = nq.pop_front();
                check("narrow_out_count", 32'(n_out_count), 32'(e.cnt));
                check("narrow_out_beats", 32'(n_out_beats), 32'(e.beats));
                check("narrow_out_overflow", 32'(n_out_overflow), 32'(e.ovf));
            end
        end
    end

    task automatic send(input logic [7:0] d, input logic l);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        while (!in_ready && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!in_ready) check("send_timeout", 32'd1, 32'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_n(input logic [7:0] d, input logic l);
        int n = 0;
        n_in_valid = 1'b1;
        n_in_data  = d;
        n_in_last  = l;
        while (!n_in_ready && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!n_in_ready) check("narrow_send_timeout", 32'd1, 32'd0);
        @(posedge clk);
        #1;
        n_in_valid = 1'b0;
        n_in_last  = 1'b0;
    endtask

    initial begin
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_data     = '0;
        in_last     = 1'b0;
        out_ready   = 1'b1;
        n_in_valid  = 1'b0;
        n_in_data   = '0;
        n_in_last   = 1'b0;
        n_out_ready = 1'b1;
        rand_done   = 1'b0;
        #12;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_count", 32'(out_count), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: single-beat frame
        q.push_back('{cnt: 16'd8, beats: 12'd1, ovf: 1'b0});
        send(8'hFF, 1'b1);
        check("t1_out_valid", 32'(out_valid), 32'd1);
        check("t1_in_ready_low", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        check("t1_in_ready_back", 32'(in_ready), 32'd1);

        // 2: back-to-back three-beat frame
        q.push_back('{cnt: 16'd9, beats: 12'd3, ovf: 1'b0});
        send(8'h0F, 1'b0);
        send(8'h01, 1'b0);
        send(8'hAA, 1'b1);
        check("t2_in_ready_hold", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;

        // 3: backpressure with in_valid driven during HOLD
        out_ready = 1'b0;
        q.push_back('{cnt: 16'd8, beats: 12'd2, ovf: 1'b0});
        send(8'h80, 1'b0);
        send(8'h7F, 1'b1);
        in_valid = 1'b1;
        in_data  = 8'hFF;
        in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("t3_out_valid", 32'(out_valid), 32'd1);
            check("t3_in_ready", 32'(in_ready), 32'd0);
            check("t3_count_stable", 32'(out_count), 32'd8);
            check("t3_beats_stable", 32'(out_beats), 32'd2);
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("t3_released", 32'(in_ready), 32'd1);
        q.push_back('{cnt: 16'd1, beats: 12'd1, ovf: 1'b0});
        send(8'h01, 1'b1);
        @(posedge clk);
        #1;

        // 4: narrow accumulator overflow, then a clean frame to show the flag clears
`ifdef POPCOUNT_ACCUM_SAT_EN
        nq.push_back('{cnt: 16'd15, beats: 12'd2, ovf: 1'b1});
`else
        nq.push_back('{cnt: 16'd0, beats: 12'd2, ovf: 1'b1});
`endif
        send_n(8'hFF, 1'b0);
        send_n(8'hFF, 1'b1);
        @(posedge clk);
        #1;
        nq.push_back('{cnt: 16'd4, beats: 12'd2, ovf: 1'b0});
        send_n(8'h07, 1'b0);
        send_n(8'h01, 1'b1);
        @(posedge clk);
        #1;

        // 5: reset mid-frame discards the partial frame and clears outputs
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        rst_n = 1'b0;
        #1;
        check("t5_rst_out_valid", 32'(out_valid), 32'd0);
        check("t5_rst_out_count", 32'(out_count), 32'd0);
        check("t5_rst_out_beats", 32'(out_beats), 32'd0);
        check("t5_rst_out_overflow", 32'(out_overflow), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        q.push_back('{cnt: 16'd2, beats: 12'd1, ovf: 1'b0});
        send(8'h03, 1'b1);
        @(posedge clk);
        #1;

        // 6: random frames with random input gaps and random output backpressure
        fork
            begin
                for (int f = 0; f < 6; f++) begin
                    int   len;
                    int   cnt;
                    logic [7:0] d [$];
                    len = (f == 0) ? 300 : int'($urandom_range(1, 120));
                    cnt = 0;
                    d.delete();
                    for (int b = 0; b < len; b++) begin
                        logic [7:0] w;
                        w = 8'($urandom);
                        d.push_back(w);
                        cnt += $countones(w);
                    end
                    q.push_back('{cnt: 16'(cnt), beats: 12'(len), ovf: 1'b0});
                    for (int b = 0; b < len; b++) begin
                        int gap;
                        gap = int'($urandom_range(0, 2));
                        for (int g = 0; g < gap; g++) begin
                            @(posedge clk);
                            #1;
                        end
                        send(d[b], (b == len - 1));
                    end
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    out_ready = 1'($urandom_range(0, 1));
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join

        for (int i = 0; i < 1000 && (q.size() != 0 || nq.size() != 0); i++) begin
            @(posedge clk);
            #1;
        end
        check("drain_main", 32'(q.size()), 32'd0);
        check("drain_narrow", 32'(nq.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
